// File: rtl/frv_pipeline_ctrl.sv
// frv_pipeline_ctrl
// Pipeline sequencing controller: derives per-stage busy/flush controls from
// stall, redirect and trap requests, and drains outstanding instruction
// fetches before steering fetch to a new PC so stale responses are dropped.

module frv_pipeline_ctrl #(
    parameter int unsigned NSTAGE = 4,
    parameter int unsigned RSTAGE = 2,
    parameter int unsigned XLEN   = 32,
    parameter int unsigned OUTW   = 2
) (
    input  logic              g_clk,
    input  logic              g_reset,
    input  logic [NSTAGE-1:0] s_stall_req,
    output logic [NSTAGE-1:0] s_busy,
    output logic [NSTAGE-1:0] s_flush,
    input  logic              redir_req,
    input  logic [XLEN-1:0]   redir_target,
    input  logic              trap_req,
    input  logic [XLEN-1:0]   trap_target,
    input  logic              f_req_issue,
    input  logic              f_rsp,
    output logic              f_can_issue,
    output logic              f_drop,
    output logic              f_redir,
    output logic [XLEN-1:0]   f_redir_pc,
    input  logic              f_redir_ack
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_REDIR = 2'd2
    } state_t;

    localparam logic [OUTW-1:0] CNT_MAX = '1;

    state_t            r_state;
    logic [OUTW-1:0]   r_cnt;
    logic [XLEN-1:0]   r_redir_pc;
    logic              r_f_redir;
    logic              r_f_drop;

    state_t            w_state_next;
    logic [XLEN-1:0]   w_pc_next;
    logic [OUTW:0]     w_cnt_next;
    logic [OUTW-1:0]   w_cnt_upd;
    logic              w_cnt_err;
    logic              w_run_redir;
    logic              w_leave;
    logic [NSTAGE-1:0] w_busy;
    logic [NSTAGE-1:0] w_flush;

    // Outstanding-fetch counter update; protocol errors hold the count
    always_comb begin
        w_cnt_next = {1'b0, r_cnt} + (OUTW+1)'(f_req_issue) - (OUTW+1)'(f_rsp);
        w_cnt_err  = (f_req_issue && !f_rsp && (r_cnt == CNT_MAX)) ||
                     (f_rsp && !f_req_issue && (r_cnt == '0));
        w_cnt_upd  = w_cnt_err ? r_cnt : w_cnt_next[OUTW-1:0];
    end

    // Next-state and restart-PC selection; a trap re-enters the redirect
    // sequence from any state and outranks a simultaneous redirect or ack
    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_redir_pc;
        w_run_redir  = (r_state == ST_RUN) && redir_req;
        w_leave      = trap_req || w_run_redir;
        if (trap_req) begin
            w_pc_next = trap_target;
        end else if (w_run_redir) begin
            w_pc_next = redir_target;
        end
        if (w_leave) begin
            w_state_next = (w_cnt_upd != '0) ? ST_DRAIN : ST_REDIR;
        end else begin
            case (r_state)
                ST_DRAIN: if (w_cnt_upd == '0) w_state_next = ST_REDIR;
                ST_REDIR: if (f_redir_ack)     w_state_next = ST_RUN;
                default:                       w_state_next = r_state;
            endcase
        end
    end

    // Busy chain: an older stage's backpressure propagates to all younger ones
    always_comb begin
        w_busy = '0;
        w_busy[NSTAGE-1] = s_stall_req[NSTAGE-1];
        for (int unsigned i = NSTAGE - 1; i > 0; i--) begin
            w_busy[i-1] = s_stall_req[i-1] | w_busy[i];
        end
        if (r_state != ST_RUN) begin
            w_busy[0] = 1'b1;
        end
    end

    // Same-cycle flush: trap clears everything, redirect only the younger stages
    always_comb begin
        w_flush = '0;
        if (trap_req) begin
            w_flush = '1;
        end else if (w_run_redir) begin
            for (int unsigned j = 0; j < RSTAGE; j++) begin
                w_flush[j] = 1'b1;
            end
        end else if (r_state != ST_RUN) begin
            w_flush[0] = 1'b1;
        end
    end

    // State, counter, restart PC and registered fetch-side outputs
    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            r_state    <= ST_RUN;
            r_cnt      <= '0;
            r_redir_pc <= '0;
            r_f_redir  <= 1'b0;
            r_f_drop   <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_cnt      <= w_cnt_upd;
            r_redir_pc <= w_pc_next;
            r_f_redir  <= (w_state_next == ST_REDIR);
            r_f_drop   <= (w_state_next != ST_RUN);
        end
    end

    assign s_busy      = w_busy;
    assign s_flush     = w_flush;
    assign f_can_issue = (r_cnt != CNT_MAX) && (r_state == ST_RUN);
    assign f_drop      = r_f_drop;
    assign f_redir     = r_f_redir;
    assign f_redir_pc  = r_redir_pc;

endmodule

// File: tb/tb_frv_pipeline_ctrl.sv
// Directed testbench for frv_pipeline_ctrl.
module tb_frv_pipeline_ctrl;

    logic        g_clk = 1'b0;
    logic        g_reset;
    logic [3:0]  s_stall_req;
    logic [3:0]  s_busy;
    logic [3:0]  s_flush;
    logic        redir_req;
    logic [31:0] redir_target;
    logic        trap_req;
    logic [31:0] trap_target;
    logic        f_req_issue;
    logic        f_rsp;
    logic        f_can_issue;
    logic        f_drop;
    logic        f_redir;
    logic [31:0] f_redir_pc;
    logic        f_redir_ack;

    int checks = 0;
    int errors = 0;

    frv_pipeline_ctrl #(.NSTAGE(4), .RSTAGE(2), .XLEN(32), .OUTW(2)) dut (
        .g_clk(g_clk), .g_reset(g_reset),
        .s_stall_req(s_stall_req), .s_busy(s_busy), .s_flush(s_flush),
        .redir_req(redir_req), .redir_target(redir_target),
        .trap_req(trap_req), .trap_target(trap_target),
        .f_req_issue(f_req_issue), .f_rsp(f_rsp),
        .f_can_issue(f_can_issue), .f_drop(f_drop),
        .f_redir(f_redir), .f_redir_pc(f_redir_pc), .f_redir_ack(f_redir_ack)
    );

    always #5 g_clk = ~g_clk;

    // advance to 1 time unit after the next rising edge
    task automatic cyc();
        @(posedge g_clk);
        #1;
    endtask

    task automatic test_reset();
        g_reset = 1'b1;
        s_stall_req = '0; redir_req = 0; redir_target = '0; trap_req = 0;
        trap_target = '0; f_req_issue = 0; f_rsp = 0; f_redir_ack = 0;
        #3;
        checks++; if (f_redir !== 1'b0) begin errors++; $display("FAIL rst_redir got %b exp 0", f_redir); end
        checks++; if (f_drop !== 1'b0) begin errors++; $display("FAIL rst_drop got %b exp 0", f_drop); end
        checks++; if (s_flush !== 4'b0000) begin errors++; $display("FAIL rst_flush got %b exp 0000", s_flush); end
        checks++; if (f_redir_pc !== 32'h0) begin errors++; $display("FAIL rst_pc got %h exp 0", f_redir_pc); end
        #9 g_reset = 1'b0;
        cyc();
        checks++; if (f_can_issue !== 1'b1) begin errors++; $display("FAIL rst_can_issue got %b exp 1", f_can_issue); end
        checks++; if (s_busy !== 4'b0000) begin errors++; $display("FAIL rst_busy got %b exp 0000", s_busy); end
    endtask

    task automatic test_stall_chain();
        s_stall_req = 4'b0100; #1;
        checks++; if (s_busy !== 4'b0111) begin errors++; $display("FAIL stall_0100 got %b exp 0111", s_busy); end
        s_stall_req = 4'b0000; #1;
        checks++; if (s_busy !== 4'b0000) begin errors++; $display("FAIL stall_rel got %b exp 0000", s_busy); end
        s_stall_req = 4'b1000; #1;
        checks++; if (s_busy !== 4'b1111) begin errors++; $display("FAIL stall_1000 got %b exp 1111", s_busy); end
        s_stall_req = 4'b0001; #1;
        checks++; if (s_busy !== 4'b0001) begin errors++; $display("FAIL stall_0001 got %b exp 0001", s_busy); end
        s_stall_req = 4'b0000;
        cyc();
    endtask

    task automatic test_redirect();
        redir_req = 1; redir_target = 32'h80; #1;
        checks++; if (s_flush !== 4'b0011) begin errors++; $display("FAIL redir_flush got %b exp 0011", s_flush); end
        cyc();
        redir_req = 0; #1;
        checks++; if (f_redir !== 1'b1) begin errors++; $display("FAIL redir_rise got %b exp 1", f_redir); end
        checks++; if (f_redir_pc !== 32'h80) begin errors++; $display("FAIL redir_pc got %h exp 80", f_redir_pc); end
        checks++; if (f_drop !== 1'b1) begin errors++; $display("FAIL redir_drop got %b exp 1", f_drop); end
        checks++; if (s_busy !== 4'b0001) begin errors++; $display("FAIL redir_busy got %b exp 0001", s_busy); end
        checks++; if (f_can_issue !== 1'b0) begin errors++; $display("FAIL redir_can_issue got %b exp 0", f_can_issue); end
        for (int k = 0; k < 3; k++) begin
            cyc();
            checks++; if (f_redir !== 1'b1 || f_redir_pc !== 32'h80) begin
                errors++; $display("FAIL redir_hold%0d got %b/%h exp 1/80", k, f_redir, f_redir_pc); end
        end
        f_redir_ack = 1;
        cyc();
        f_redir_ack = 0; #1;
        checks++; if (f_redir !== 1'b0) begin errors++; $display("FAIL redir_ack_redir got %b exp 0", f_redir); end
        checks++; if (f_can_issue !== 1'b1) begin errors++; $display("FAIL redir_ack_can_issue got %b exp 1", f_can_issue); end
        checks++; if (s_busy !== 4'b0000) begin errors++; $display("FAIL redir_ack_busy got %b exp 0000", s_busy); end
    endtask

    task automatic test_drain();
        f_req_issue = 1;
        cyc(); cyc();
        checks++; if (f_can_issue !== 1'b1) begin errors++; $display("FAIL drain_can_issue2 got %b exp 1", f_can_issue); end
        cyc();
        f_req_issue = 0; #1;
        checks++; if (f_can_issue !== 1'b0) begin errors++; $display("FAIL drain_can_issue3 got %b exp 0", f_can_issue); end
        redir_req = 1; redir_target = 32'h44;
        cyc();
        redir_req = 0;
        for (int k = 1; k <= 5; k++) begin
            f_rsp = (k == 2 || k == 3 || k == 5); #1;
            checks++; if (f_redir !== 1'b0 || f_drop !== 1'b1 || s_flush !== 4'b0001) begin
                errors++; $display("FAIL drain_c%0d got redir %b drop %b flush %b exp 0 1 0001", k, f_redir, f_drop, s_flush); end
            cyc();
        end
        f_rsp = 0; #1;
        checks++; if (f_redir !== 1'b1) begin errors++; $display("FAIL drain_redir got %b exp 1", f_redir); end
        checks++; if (f_redir_pc !== 32'h44) begin errors++; $display("FAIL drain_pc got %h exp 44", f_redir_pc); end
        f_redir_ack = 1;
        cyc();
        f_redir_ack = 0; #1;
        checks++; if (f_can_issue !== 1'b1) begin errors++; $display("FAIL drain_done got %b exp 1", f_can_issue); end
    endtask

    task automatic test_trap();
        trap_req = 1; trap_target = 32'h100; redir_req = 1; redir_target = 32'h80; #1;
        checks++; if (s_flush !== 4'b1111) begin errors++; $display("FAIL trap_flush got %b exp 1111", s_flush); end
        cyc();
        trap_req = 0; redir_req = 0; #1;
        checks++; if (f_redir !== 1'b1 || f_redir_pc !== 32'h100) begin
            errors++; $display("FAIL trap_pc got %b/%h exp 1/100", f_redir, f_redir_pc); end
        // redirect in REDIR is ignored
        redir_req = 1; redir_target = 32'h999; #1;
        checks++; if (s_flush !== 4'b0001) begin errors++; $display("FAIL trap_ign_flush got %b exp 0001", s_flush); end
        cyc();
        redir_req = 0; #1;
        checks++; if (f_redir_pc !== 32'h100) begin errors++; $display("FAIL trap_ign_pc got %h exp 100", f_redir_pc); end
        trap_req = 1; trap_target = 32'h200; #1;
        checks++; if (s_flush !== 4'b1111) begin errors++; $display("FAIL trap_redir_flush got %b exp 1111", s_flush); end
        cyc();
        trap_req = 0; #1;
        checks++; if (f_redir !== 1'b1 || f_redir_pc !== 32'h200) begin
            errors++; $display("FAIL trap_redir_pc got %b/%h exp 1/200", f_redir, f_redir_pc); end
        trap_req = 1; trap_target = 32'h300; f_redir_ack = 1;
        cyc();
        trap_req = 0; f_redir_ack = 0; #1;
        checks++; if (f_redir !== 1'b1 || f_redir_pc !== 32'h300) begin
            errors++; $display("FAIL trap_ack_pc got %b/%h exp 1/300", f_redir, f_redir_pc); end
        f_redir_ack = 1;
        cyc();
        f_redir_ack = 0; #1;
        checks++; if (f_redir !== 1'b0 || f_can_issue !== 1'b1) begin
            errors++; $display("FAIL trap_done got %b/%b exp 0/1", f_redir, f_can_issue); end
    endtask

    task automatic test_counter();
        f_req_issue = 1;
        cyc(); cyc(); cyc();
        #1;
        checks++; if (f_can_issue !== 1'b0) begin errors++; $display("FAIL cnt_max_can got %b exp 0", f_can_issue); end
        cyc();
        f_req_issue = 0;
        redir_req = 1; redir_target = 32'h60;
        cyc();
        redir_req = 0;
        for (int k = 1; k <= 3; k++) begin
            f_rsp = 1; #1;
            checks++; if (f_redir !== 1'b0) begin errors++; $display("FAIL cnt_max_hold%0d got %b exp 0", k, f_redir); end
            cyc();
        end
        f_rsp = 0; #1;
        checks++; if (f_redir !== 1'b1) begin errors++; $display("FAIL cnt_max_redir got %b exp 1", f_redir); end
        f_redir_ack = 1;
        cyc();
        f_redir_ack = 0;
        f_rsp = 1;
        cyc();
        f_rsp = 0; #1;
        checks++; if (f_can_issue !== 1'b1) begin errors++; $display("FAIL cnt_zero_can got %b exp 1", f_can_issue); end
        f_req_issue = 1;
        cyc();
        f_rsp = 1;
        cyc();
        f_req_issue = 0; f_rsp = 0;
        redir_req = 1; redir_target = 32'h70;
        cyc();
        redir_req = 0; #1;
        checks++; if (f_redir !== 1'b0 || f_drop !== 1'b1) begin
            errors++; $display("FAIL cnt_simul_drain got %b/%b exp 0/1", f_redir, f_drop); end
        f_rsp = 1;
        cyc();
        f_rsp = 0; #1;
        checks++; if (f_redir !== 1'b1 || f_redir_pc !== 32'h70) begin
            errors++; $display("FAIL cnt_simul_redir got %b/%h exp 1/70", f_redir, f_redir_pc); end
        f_redir_ack = 1;
        cyc();
        f_redir_ack = 0;
    endtask

    task automatic test_reset_midseq();
        f_req_issue = 1;
        cyc(); cyc();
        f_req_issue = 0;
        redir_req = 1; redir_target = 32'h500;
        cyc();
        redir_req = 0; #1;
        checks++; if (f_drop !== 1'b1) begin errors++; $display("FAIL mid_pre_drop got %b exp 1", f_drop); end
        #1 g_reset = 1'b1;
        #1;
        checks++; if (f_drop !== 1'b0 || f_redir !== 1'b0) begin
            errors++; $display("FAIL mid_rst_state got %b/%b exp 0/0", f_drop, f_redir); end
        checks++; if (f_redir_pc !== 32'h0) begin errors++; $display("FAIL mid_rst_pc got %h exp 0", f_redir_pc); end
        checks++; if (f_can_issue !== 1'b1 || s_flush !== 4'b0000 || s_busy !== 4'b0000) begin
            errors++; $display("FAIL mid_rst_out got %b/%b/%b exp 1/0000/0000", f_can_issue, s_flush, s_busy); end
        #2 g_reset = 1'b0;
        cyc(); cyc();
        checks++; if (f_drop !== 1'b0 || f_can_issue !== 1'b1) begin
            errors++; $display("FAIL mid_after got %b/%b exp 0/1", f_drop, f_can_issue); end
    endtask

    initial begin
        test_reset();
        test_stall_chain();
        test_redirect();
        test_drain();
        test_trap();
        test_counter();
        test_reset_midseq();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/frv_pipeline_ctrl.md
# frv_pipeline_ctrl

Sequencing controller for the core's chain of pipeline stage registers and the fetch front-end. It derives each stage register's busy (backpressure) and flush controls from per-stage stall requests, redirect requests and trap requests. It drains in-flight instruction fetches before redirecting fetch to a new PC, so stale responses never enter the pipeline. Sits beside the stage registers; one instance per core.

## Interface
- NSTAGE, 4: number of pipeline stage registers; index 0 is the youngest (fetch output), NSTAGE-1 the oldest.
- RSTAGE, 2: index of the stage register holding an instruction that may raise redir_req (execute).
- XLEN, 32: PC width.
- OUTW, 2: width of the outstanding-fetch counter; maximum outstanding fetches is 2^OUTW-1.

- g_clk  in  1  clock; all state updates on rising edge.
- g_reset  in  1  reset, asynchronous, active-high.
- s_stall_req  in  NSTAGE  stage i consumer cannot accept data this cycle.
- s_busy  out  NSTAGE  drives i_busy of stage register i.
- s_flush  out  NSTAGE  drives flush of stage register i.
- redir_req  in  1  instruction in stage RSTAGE requests a control-flow redirect.
- redir_target  in  XLEN  redirect PC; valid with redir_req.
- trap_req  in  1  trap/exception; flushes the whole pipeline.
- trap_target  in  XLEN  trap vector PC; valid with trap_req.
- f_req_issue  in  1  fetch issued one memory request this cycle.
- f_rsp  in  1  one fetch response returned this cycle.
- f_can_issue  out  1  fetch may issue a request this cycle.
- f_drop  out  1  fetch must discard any response this cycle.
- f_redir  out  1  fetch must restart at f_redir_pc; held until acknowledged.
- f_redir_pc  out  XLEN  restart PC.
- f_redir_ack  in  1  fetch accepted the redirect.

## Operation
- States: RUN, DRAIN, REDIR. Reset state RUN.
- Reset values: state RUN, outstanding counter 0, f_redir_pc 0. f_redir 0 and f_drop 0; s_flush all 0 (all state-derived). s_busy and f_can_issue follow the combinational rules below.
- Busy chain in all states: s_busy[NSTAGE-1] = s_stall_req[NSTAGE-1]; for i < NSTAGE-1, s_busy[i] = s_stall_req[i] | s_busy[i+1]. In DRAIN and REDIR, s_busy[0] is also forced to 1.
- Outstanding counter cnt: next = cnt + f_req_issue - f_rsp, computed in OUTW+1 bits. f_can_issue = (cnt != 2^OUTW-1) and state == RUN. An issue at cnt max, or a response at cnt 0, is a protocol error. Hold cnt unchanged on either event; no wrap.
- RUN, trap_req=1: combinationally assert s_flush[NSTAGE-1:0] all 1 this cycle. Latch trap_target into f_redir_pc.
- RUN, redir_req=1 and trap_req=0: combinationally assert s_flush[j]=1 for j < RSTAGE only. Older stages are untouched. Latch redir_target.
- Trap and redirect in the same cycle: trap wins (full flush, trap_target).
- Leaving RUN on either request: go to DRAIN if the post-update cnt != 0, else go to REDIR.
- DRAIN: f_drop=1, s_flush[0]=1 every cycle. When post-update cnt == 0, go to REDIR.
- REDIR: f_redir=1, f_drop=1, s_flush[0]=1. When f_redir_ack=1, go to RUN next cycle.
- trap_req in DRAIN or REDIR: assert all s_flush this cycle and re-latch f_redir_pc = trap_target. The state transition is re-evaluated as if from RUN; a REDIR with pending trap restarts via DRAIN if cnt != 0. A trap in REDIR in the same cycle as f_redir_ack re-enters REDIR with the new PC; it does not return to RUN.
- redir_req outside RUN: ignored.
- Reset asserted mid-sequence: state returns immediately to RUN, cnt 0, latched PC 0. Redirect is abandoned.

## Timing
- Flush latency 0: s_flush is asserted in the same cycle as the request.
- f_redir rises 1 cycle after the request when cnt==0 after update. Otherwise it rises 1 cycle after the cycle in which the last outstanding response returns.
- f_redir_pc is stable for the whole time f_redir=1, except when re-latched by a trap.
- After f_redir_ack, s_busy[0] is released and f_can_issue rises in the following cycle (RUN).

## Test plan
- Reset: assert g_reset asynchronously mid-cycle -> state RUN, f_redir=0, f_drop=0, s_flush=0, and f_can_issue=1 once reset is released with all stall_req=0.
- Stall chain: s_stall_req=4'b0100 -> s_busy=4'b0111; release -> s_busy=4'b0000 the same cycle.
- Redirect with no outstanding fetches: redir_req=1, target 0x80 -> s_flush=4'b0011 that cycle. Next cycle f_redir=1, f_redir_pc=0x80. Hold f_redir_ack low 3 cycles, then ack -> RUN, f_can_issue=1 the cycle after.
- Drain: issue 3 fetches (cnt=3), then redir_req -> DRAIN with f_drop=1. Return responses on cycles +2, +3, +5 -> f_redir rises the cycle after the third response. Confirm f_can_issue=0 at cnt=3.
- Trap priority and override: trap_req and redir_req together (targets 0x100 and 0x80) -> s_flush=4'b1111, f_redir_pc=0x100. Repeat with the trap arriving in REDIR -> all stages flushed again and f_redir_pc updated to the new trap_target.
- Counter boundaries: f_req_issue with cnt=3 -> cnt stays 3. f_rsp with cnt=0 -> cnt stays 0. Simultaneous issue and rsp at cnt=1 -> cnt stays 1.
